// File: rtl/urv_dm_wb_master.sv
// urv_dm_wb_master: bridges the CPU data-memory port to a pipelined Wishbone B4 master
//   clk_i, rst_i                  clock, synchronous active-high reset
//   dm_addr_i/data_s_i/select_i   CPU request address, store data, byte lanes
//   dm_store_i, dm_load_i         CPU requests (store wins when both are set)
//   dm_ready_o                    request accepted this cycle when high
//   dm_data_l_o, dm_*_done_o      load data and one-cycle completion pulses
//   bus_err_o                     sticky error/timeout flag
//   wb_*                          pipelined Wishbone master port
module urv_dm_wb_master #(
  parameter int unsigned g_timeout  = 255,
  parameter logic [31:0] g_err_data = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        bus_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);
  typedef enum logic [1:0] {IDLE, STROBE, WAIT_ACK} state_t;
  // the counter holds the number of completed bus cycles, so the last allowed one is g_timeout-1
  localparam logic [15:0] CNT_LAST = 16'(g_timeout - 1);
  state_t state, state_n;
  logic [15:0] cnt;
  logic accept, fin, bad;
  assign dm_ready_o = state == IDLE;
  assign wb_cyc_o   = state != IDLE;
  assign wb_stb_o   = state == STROBE;
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_n;
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    fin     = 1'b0;
    bad     = 1'b0;
    case (state)
      IDLE: begin
        accept  = dm_load_i | dm_store_i;
        state_n = accept ? STROBE : IDLE;
      end
      STROBE, WAIT_ACK: begin
        // a real response beats a simultaneous timeout; ERR beats ACK
        fin     = wb_ack_i | wb_err_i | (cnt == CNT_LAST);
        bad     = wb_err_i | ~wb_ack_i;
        state_n = fin ? IDLE : (state == STROBE && !wb_stall_i) ? WAIT_ACK : state;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt             <= '0;
      wb_adr_o        <= '0;
      wb_dat_o        <= '0;
      wb_sel_o        <= '0;
      wb_we_o         <= 1'b0;
      dm_data_l_o     <= '0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      bus_err_o       <= 1'b0;
    end else begin
      dm_load_done_o  <= fin & ~wb_we_o;
      dm_store_done_o <= fin & wb_we_o;
      bus_err_o       <= bus_err_o | (fin & bad);
      cnt             <= accept ? '0 : (state != IDLE) ? cnt + 16'd1 : cnt;
      if (accept) begin
        wb_adr_o <= dm_addr_i & ~32'h3;
        wb_dat_o <= dm_data_s_i;
        wb_sel_o <= dm_data_select_i;
        wb_we_o  <= dm_store_i;
      end
      if (fin && !wb_we_o) dm_data_l_o <= bad ? g_err_data : wb_dat_i;
    end
  end
endmodule

// File: tb/tb_urv_dm_wb_master.sv
// tb_urv_dm_wb_master: directed plus randomized transactions checked against a transaction-level model
module tb_urv_dm_wb_master;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] dm_addr_i = '0, dm_data_s_i = '0, dm_data_l_o, wb_adr_o, wb_dat_o, wb_dat_i = '0;
  logic [3:0]  dm_data_select_i = '0, wb_sel_o;
  logic dm_store_i = 0, dm_load_i = 0, dm_ready_o, dm_load_done_o, dm_store_done_o, bus_err_o;
  logic wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i = 0, wb_err_i = 0, wb_stall_i = 0;
  int checks = 0, errors = 0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_dl  = '0;
  urv_dm_wb_master #(.g_timeout(TO), .g_err_data(ERRD)) dut (
    .clk_i(clk), .rst_i(rst),
    .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
    .dm_store_i(dm_store_i), .dm_load_i(dm_load_i), .dm_ready_o(dm_ready_o),
    .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o), .dm_store_done_o(dm_store_done_o),
    .bus_err_o(bus_err_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle_bus();
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;
    wb_stall_i = 1'b0;
    wb_dat_i   = $urandom;
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_cyc"}, wb_cyc_o, 0);
    chk({tag, "_stb"}, wb_stb_o, 0);
    chk({tag, "_ready"}, dm_ready_o, 1);
    chk({tag, "_done"}, {dm_load_done_o, dm_store_done_o}, 0);
    chk({tag, "_dl"}, dm_data_l_o, exp_dl);
    chk({tag, "_berr"}, bus_err_o, exp_err);
  endtask
  // resp: 0 = ACK, 1 = ERR, 2 = silent slave. The slave stalls for 'stall' cycles of STB
  // and answers 'wait_n' cycles after the strobe is accepted (0 = with the strobe).
  task automatic txn(input bit st, input bit ld, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int stall, input int wait_n, input int resp,
                     input logic [31:0] rdat, input bit gap);
    int r, f;
    bit bad;
    chk("ready_idle", dm_ready_o, 1);
    dm_addr_i = a; dm_data_s_i = d; dm_data_select_i = s; dm_store_i = st; dm_load_i = ld;
    step();
    dm_store_i = 0; dm_load_i = 0;
    dm_addr_i = $urandom; dm_data_s_i = $urandom; dm_data_select_i = 4'($urandom);
    chk("adr", wb_adr_o, {a[31:2], 2'b00});
    chk("we", wb_we_o, st);
    chk("sel", wb_sel_o, s);
    chk("dat", wb_dat_o, d);
    r   = stall + wait_n;
    bad = resp != 0 || r > TO - 1;
    f   = (resp != 2 && r <= TO - 1) ? r : TO - 1;
    for (int k = 0; k <= f; k++) begin
      wb_stall_i = k < stall;
      wb_ack_i   = resp == 0 && k == r;
      wb_err_i   = resp == 1 && k == r;
      wb_dat_i   = rdat;
      chk("cyc_busy", wb_cyc_o, 1);
      chk("stb_busy", wb_stb_o, k <= stall);
      chk("ready_busy", dm_ready_o, 0);
      chk("done_busy", {dm_load_done_o, dm_store_done_o}, 0);
      step();
    end
    idle_bus();
    if (!st) exp_dl = bad ? ERRD : rdat;
    exp_err = exp_err | bad;
    chk("cyc_end", wb_cyc_o, 0);
    chk("stb_end", wb_stb_o, 0);
    chk("ready_end", dm_ready_o, 1);
    chk("load_done", dm_load_done_o, !st);
    chk("store_done", dm_store_done_o, st);
    chk("data_l", dm_data_l_o, exp_dl);
    chk("bus_err", bus_err_o, exp_err);
    if (gap) begin
      step();
      chk_quiet("gap");
    end
  endtask
  initial begin
    idle_bus();
    repeat (3) step();
    rst = 1'b0;
    chk("rst_we", wb_we_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_wdat", wb_dat_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk_quiet("rst");
    step();
    txn(0, 1, 32'h0000_1003, 32'h0, 4'hf, 0, 0, 0, 32'hCAFE_BABE, 1);
    txn(1, 0, 32'h0000_2000, 32'h1122_3344, 4'b0010, 3, 0, 0, 32'h0, 0);
    txn(0, 1, 32'h0000_3008, 32'h0, 4'hf, 0, 2, 1, 32'h5555_AAAA, 1);
    txn(0, 1, 32'h0000_300c, 32'h0, 4'hf, 1, 1, 0, 32'h1234_5678, 1);
    txn(0, 1, 32'h0000_4000, 32'h0, 4'hf, 0, 0, 2, 32'h7777_7777, 0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_0BAD;
    step();
    idle_bus();
    chk_quiet("stray0");
    step();
    chk_quiet("stray1");
    txn(1, 1, 32'h0000_5005, 32'hA5A5_5A5A, 4'b1100, 1, 1, 0, 32'h0, 1);
    dm_load_i = 1'b1; dm_addr_i = 32'h0000_6000;
    step();
    dm_load_i = 1'b0;
    step();
    step();
    chk("wait_cyc", wb_cyc_o, 1);
    chk("wait_stb", wb_stb_o, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_err = 1'b0;
    exp_dl  = '0;
    chk_quiet("midrst");
    txn(0, 1, 32'h0000_7004, 32'h0, 4'hf, 0, 1, 0, 32'h0F0F_F0F0, 1);
    for (int i = 0; i < 40; i++) begin
      bit st, ld;
      int rs;
      st = 1'($urandom);
      ld = st ? 1'($urandom) : 1'b1;
      rs = $urandom_range(0, 5);
      txn(st, ld, $urandom, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 5),
          rs < 4 ? 0 : rs - 3, $urandom, 1'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
